p1v_reset_sequencer: RTL and testbench

- Sole owner of the P1V core's active-low reset input, `inp_resn`.
- Combines three reset sources into one clean, registered reset:
  - PLL lock / power-on.
  - The board push-button: debounced, then stretched to a minimum hold time.
  - The Prop Plug reset line: glitch-filtered only, not stretched, because the plug handles its own timing.
- Sits between the clock generator, board I/O and the p1v instance; replaces the ad-hoc button-pulse and AND-gate reset mixing.

---
 rtl/p1v_reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_p1v_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p1v_reset_sequencer.sv
// p1v_reset_sequencer: produces the single registered active-low reset for the
// P1V core. It merges three sources: PLL lock / power-on, a debounced and
// stretched board push-button, and a glitch-filtered Prop Plug reset line.
// The one-cycle release strobe is named release_pulse because `release` is a
// reserved word in SystemVerilog.
// Optional feature macro: P1V_RESET_CAUSE_EN adds the cause[1:0] output.
module p1v_reset_sequencer #(
    parameter int HOLD_CYCLES     = 8000000,
    parameter int DEBOUNCE_CYCLES = 1600000,
    parameter int PLUG_MIN_CYCLES = 16,
    parameter int SYNC_STAGES     = 2        // minimum 2
) (
    input  logic       clock_160,
    input  logic       res,
    input  logic       pll_locked,
    input  logic       key_n,
    input  logic       plug_resn,
    output logic       inp_resn,
    output logic       release_pulse
`ifdef P1V_RESET_CAUSE_EN
    ,
    output logic [1:0] cause
`endif
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > DEBOUNCE_CYCLES) ? HOLD_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int PLUG_W     = $clog2(PLUG_MIN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PLUG_W-1:0] PLUG_LAST = PLUG_W'(PLUG_MIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKWAIT,
        ST_HOLD,
        ST_RUN,
        ST_DEBOUNCE
    } state_t;

    logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
    logic [SYNC_STAGES-1:0] plug_sync_q, plug_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   key_s, plug_s, locked_s;

    logic [PLUG_W-1:0]      plug_cnt_q, plug_cnt_d;
    logic                   plug_low_q, plug_low_d;
    logic                   plug_f;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   inp_resn_q, inp_resn_d;
    logic                   release_q, release_d;

    assign key_s    = key_sync_q[SYNC_STAGES-1];
    assign plug_s   = plug_sync_q[SYNC_STAGES-1];
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    // A plug that reads high releases its hold immediately, without waiting a cycle.
    assign plug_f = plug_s | ~plug_low_q;

    // Synchronizer shift chains and plug glitch filter next-state.
    always_comb begin
        key_sync_d  = {key_sync_q[SYNC_STAGES-2:0], key_n};
        plug_sync_d = {plug_sync_q[SYNC_STAGES-2:0], plug_resn};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};

        // Count consecutive low samples, saturating once the filter has tripped.
        if (plug_s) begin
            plug_cnt_d = '0;
            plug_low_d = 1'b0;
        end else begin
            plug_cnt_d = (plug_cnt_q == PLUG_LAST) ? plug_cnt_q : plug_cnt_q + 1'b1;
            plug_low_d = plug_low_q | (plug_cnt_q == PLUG_LAST);
        end
    end

    // Sequencer next-state, shared hold/debounce counter and reset output.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!locked_s) begin
            // Losing lock overrides everything else.
            state_d = ST_LOCKWAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOCKWAIT: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (!key_s) begin
                        cnt_d = HOLD_LOAD;        // holding the button extends reset
                    end else if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!key_s) begin
                        state_d = ST_DEBOUNCE;
                        cnt_d   = DEB_LOAD;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_s) begin
                        state_d = ST_RUN;         // bounce: back to normal operation
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LOCKWAIT;
                    cnt_d   = '0;
                end
            endcase
        end

        inp_resn_d = ((state_d == ST_RUN) || (state_d == ST_DEBOUNCE)) && plug_f;
        release_d  = inp_resn_d & ~inp_resn_q;
    end

    // State registers; res puts everything back to the power-on state.
    always_ff @(posedge clock_160) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (res) begin
            key_sync_q  <= '1;
            plug_sync_q <= '1;
            lock_sync_q <= '0;
            plug_cnt_q  <= '0;
            plug_low_q  <= 1'b0;
            state_q     <= ST_LOCKWAIT;
            cnt_q       <= '0;
            inp_resn_q  <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            key_sync_q  <= key_sync_d;
            plug_sync_q <= plug_sync_d;
            lock_sync_q <= lock_sync_d;
            plug_cnt_q  <= plug_cnt_d;
            plug_low_q  <= plug_low_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inp_resn_q  <= inp_resn_d;
            release_q   <= release_d;
        end
    end

    assign inp_resn      = inp_resn_q;
    assign release_pulse = release_q;

`ifdef P1V_RESET_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    // Capture the reset source on each falling edge of inp_resn (PLL > button > plug).
    always_comb begin
        cause_d = cause_q;
        if (inp_resn_q && !inp_resn_d) begin
            if (state_d == ST_LOCKWAIT) begin
                cause_d = 2'b00;
            end else if (state_d == ST_HOLD) begin
                cause_d = 2'b01;
            end else begin
                cause_d = 2'b10;
            end
        end
    end

    // Cause register, held until the next fall.
    always_ff @(posedge clock_160) begin
        if (res) begin
            cause_q <= 2'b00;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause = cause_q;
`endif

endmodule

// File: tb/tb_p1v_reset_sequencer.sv
// Testbench for p1v_reset_sequencer: directed scenarios followed by random
// input toggling, all compared each cycle against a timestamp-based model.
module tb_p1v_reset_sequencer;

    localparam int HOLD = 20;
    localparam int DEB  = 8;
    localparam int PMIN = 4;
    localparam int SYNC = 2;

    localparam int M_WAIT = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res, pll_locked, key_n, plug_resn;
    logic inp_resn, release_pulse;
`ifdef P1V_RESET_CAUSE_EN
    logic [1:0] cause;
`endif

    p1v_reset_sequencer #(
        .HOLD_CYCLES     (HOLD),
        .DEBOUNCE_CYCLES (DEB),
        .PLUG_MIN_CYCLES (PMIN),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clock_160     (clk),
        .res           (res),
        .pll_locked    (pll_locked),
        .key_n         (key_n),
        .plug_resn     (plug_resn),
        .inp_resn      (inp_resn),
        .release_pulse (release_pulse)
`ifdef P1V_RESET_CAUSE_EN
        ,
        .cause         (cause)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int low_seen = 0;
    int rel_seen = 0;

    // Reference model: synchronizers as delay queues, timers as absolute deadlines.
    bit kq[$];
    bit pq[$];
    bit lq[$];
    int mode     = M_WAIT;
    int hold_end = 0;
    int deb_end  = 0;
    int plug_run = 0;
    bit m_inp    = 1'b0;
    bit m_rel    = 1'b0;
    int m_cause  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        kq = {};
        pq = {};
        lq = {};
        repeat (SYNC) begin
            kq.push_back(1'b1);
            pq.push_back(1'b1);
            lq.push_back(1'b0);
        end
        mode     = M_WAIT;
        plug_run = 0;
        m_inp    = 1'b0;
        m_rel    = 1'b0;
        m_cause  = 0;
    endtask

    task automatic model_edge();
        bit ks, ps, ls, plug_ok, new_inp;
        cyc++;
        if (res) begin
            model_reset();
        end else begin
            ks = kq.pop_front(); kq.push_back(key_n);
            ps = pq.pop_front(); pq.push_back(plug_resn);
            ls = lq.pop_front(); lq.push_back(pll_locked);

            // Plug blocks once PMIN consecutive low samples have been taken.
            plug_ok  = ps || (plug_run < PMIN);
            plug_run = ps ? 0 : plug_run + 1;

            if (!ls) begin
                mode = M_WAIT;
            end else if (mode == M_WAIT) begin
                mode = M_HOLD;
                hold_end = cyc + HOLD;
            end else if (mode == M_HOLD) begin
                if (!ks) hold_end = cyc + HOLD;
                else if (cyc >= hold_end) mode = M_RUN;
            end else if (mode == M_RUN) begin
                if (!ks) begin
                    mode = M_DEB;
                    deb_end = cyc + DEB;
                end
            end else begin
                if (ks) mode = M_RUN;
                else if (cyc >= deb_end) begin
                    mode = M_HOLD;
                    hold_end = cyc + HOLD;
                end
            end

            new_inp = ((mode == M_RUN) || (mode == M_DEB)) && plug_ok;
            if (m_inp && !new_inp) m_cause = (mode == M_WAIT) ? 0 : (mode == M_HOLD) ? 1 : 2;
            m_rel = new_inp && !m_inp;
            m_inp = new_inp;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("inp_resn", 32'(inp_resn), 32'(m_inp));
        check("release", 32'(release_pulse), 32'(m_rel));
`ifdef P1V_RESET_CAUSE_EN
        check("cause", 32'(cause), 32'(m_cause));
`endif
        if (inp_resn !== 1'b1) low_seen++;
        if (release_pulse === 1'b1) rel_seen++;
    endtask

    // Ticks until inp_resn reaches lvl; at = tick count, or -1 if the bound expires.
    task automatic wait_level(input logic lvl, input int limit, output int at);
        at = -1;
        for (int i = 1; i <= limit && at < 0; i++) begin
            tick();
            if (inp_resn === lvl) at = i;
        end
    endtask

    task automatic check_cause(input string tag, input int exp);
`ifdef P1V_RESET_CAUSE_EN
        check(tag, 32'(cause), 32'(exp));
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    initial begin
        int at;
        res = 1'b1; pll_locked = 1'b1; key_n = 1'b1; plug_resn = 1'b1;
        model_reset();

        // Power-on: 5 cycles of res, then lock sync + full hold.
        repeat (5) tick();
        res = 1'b0;
        wait_level(1'b1, 60, at);
        check("poweron_rise", 32'(at), 32'(SYNC + 1 + HOLD));
        check("poweron_release", 32'(release_pulse), 32'd1);
        tick();
        check("poweron_release_width", 32'(release_pulse), 32'd0);
        repeat (5) tick();

        // Button bounce shorter than debounce.
        low_seen = 0; rel_seen = 0;
        key_n = 1'b0; repeat (6) tick(); key_n = 1'b1;
        repeat (20) tick();
        check("bounce_low_cycles", 32'(low_seen), 32'd0);
        check("bounce_release", 32'(rel_seen), 32'd0);

        // Clean 12-cycle press.
        key_n = 1'b0;
        wait_level(1'b0, 12, at);
        check("button_fall", 32'(at), 32'(SYNC + DEB + 1));
        tick();
        key_n = 1'b1;
        wait_level(1'b1, 60, at);
        check("button_rise", 32'(at), 32'(SYNC + HOLD));
        check_cause("button_cause", 1);
        repeat (5) tick();

        // Plug glitch, then a real plug reset.
        low_seen = 0;
        plug_resn = 1'b0; repeat (3) tick(); plug_resn = 1'b1;
        repeat (10) tick();
        check("plug_glitch_low_cycles", 32'(low_seen), 32'd0);
        rel_seen = 0;
        plug_resn = 1'b0;
        wait_level(1'b0, 10, at);
        check("plug_fall", 32'(at), 32'(SYNC + PMIN + 1));
        repeat (3) tick();
        plug_resn = 1'b1;
        wait_level(1'b1, 20, at);
        check("plug_rise", 32'(at), 32'(SYNC + 1));
        check("plug_release_count", 32'(rel_seen), 32'd1);
        check_cause("plug_cause", 2);
        repeat (5) tick();

        // PLL loss and relock.
        pll_locked = 1'b0;
        wait_level(1'b0, 10, at);
        check("pll_fall", 32'(at), 32'(SYNC + 1));
        repeat (5) tick();
        pll_locked = 1'b1;
        wait_level(1'b1, 60, at);
        check("pll_relock_rise", 32'(at), 32'(SYNC + 1 + HOLD));
        check_cause("pll_cause", 0);
        repeat (5) tick();

        // res asserted in the middle of a debounce.
        key_n = 1'b0; repeat (6) tick();
        res = 1'b1; tick();
        check("res_mid_inp", 32'(inp_resn), 32'd0);
        check("res_mid_release", 32'(release_pulse), 32'd0);
        res = 1'b0; key_n = 1'b1; rel_seen = 0;
        wait_level(1'b1, 60, at);
        check("res_mid_rise", 32'(at), 32'(SYNC + 1 + HOLD));
        check("res_mid_release_count", 32'(rel_seen), 32'd1);
        repeat (5) tick();

        // Button and plug fall together and stay low.
        key_n = 1'b0; plug_resn = 1'b0;
        wait_level(1'b0, 20, at);
        check("simul_fall", 32'(at), 32'(SYNC + PMIN + 1));
        check_cause("simul_cause", 2);
        repeat (30) tick();
        key_n = 1'b1; plug_resn = 1'b1;
        wait_level(1'b1, 60, at);
        check("simul_rise", 32'(at), 32'(SYNC + HOLD));

        // Random toggling of all inputs, model-checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11, 0) == 0) key_n = ~key_n;
            if ($urandom_range(9, 0) == 0) plug_resn = ~plug_resn;
            if (pll_locked ? ($urandom_range(199, 0) == 0) : ($urandom_range(4, 0) == 0))
                pll_locked = ~pll_locked;
            res = ($urandom_range(399, 0) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
